key_event_decoder: RTL

- Consumes the debounced key press pulse and the debounced key level produced by the key debounce stage.
- Classifies each gesture into exactly one of three events: single click, double click or long press.
- Each event is emitted as a one-cycle pulse for the LED/mode-control logic downstream.
- Pure timing FSM plus one shared counter; single clock domain.

---
 rtl/key_event_decoder.sv | 109 ++++++++++
 1 files changed

// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_event_decoder
// Description : Classifies debounced key gestures into single click, double
//               click or long press, each emitted as a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
    parameter int LONG_CNT = 1000,
    parameter int DBL_GAP  = 500,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_level,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_LONG_HOLD = 3'd2,
        S_WAIT2     = 3'd3,
        S_PRESS2    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(DBL_GAP - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    // Every transition clears the counter; busy tracks the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (key_flag) begin
                        r_state <= S_PRESS1;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_PRESS1: begin
                    if (!key_level) begin
                        r_state <= S_WAIT2;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_LONG_LAST) begin
                        r_state    <= S_LONG_HOLD;
                        r_cnt      <= '0;
                        long_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LONG_HOLD: begin
                    if (!key_level) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end
                end
                S_WAIT2: begin
                    // A second press on the expiry cycle still counts as a double click.
                    if (key_flag) begin
                        r_state <= S_PRESS2;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_GAP_LAST) begin
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                        single_click <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PRESS2: begin
                    if (!key_level) begin
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                        double_click <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
